goldschmidt_seq: RTL and testbench
==================================

// Module: goldschmidt_seq
// PURPOSE
//  Sequencer for the Goldschmidt iterative divider in the mantissa-divide path.
//  - Accepts one operand pair via valid/ready and holds it stable for the datapath.
//  - Drives the datapath control (load/mode/stage/rem) through a fixed iteration schedule.
//  - Captures the quotient and holds it until the consumer accepts it.
// PARAMETERS
//  WIDTH    30  operand/quotient width (lead + mantissa + guard bits)
//  ITERS    4   Goldschmidt iterations per divide, >=1
//  MUL_LAT  1   datapath cycles per stage (multiplier latency), >=1
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous reset, active-low (0 = in reset)
//  in_valid       in   1      operand pair valid
//  in_ready       out  1      sequencer can accept operands
//  in_num         in   WIDTH  dividend
//  in_den         in   WIDTH  divisor
//  flush          in   1      synchronous abort; return to IDLE
//  dp_num         out  WIDTH  latched dividend to datapath
//  dp_den         out  WIDTH  latched divisor to datapath
//  dp_load        out  1      datapath loads dp_num/dp_den this cycle
//  dp_mode        out  1      0 = load/hold, 1 = iterate
//  dp_stage       out  1      0 = form factor F=2-D, 1 = multiply N*F, D*F
//  dp_rem         out  1      high throughout the final iteration
//  dp_quotient    in   WIDTH  datapath quotient, valid in CAPTURE
//  out_valid      out  1      result valid
//  out_ready      in   1      consumer accepts result
//  out_quotient   out  WIDTH  registered quotient
//  out_dz         out  1      divide-by-zero flag, qualified by out_valid
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; all outputs 0 except in_ready=1.
//    Reset mid-divide abandons the operation with no result.
//  - States: IDLE, LOAD, ITER, CAPTURE, DONE.
//    Counters: iter (0..ITERS-1), phase (stage bit), lat (0..MUL_LAT-1).
//  - IDLE: in_ready=1. On in_valid&in_ready, latch in_num/in_den into dp_num/dp_den.
//    - Next state LOAD.
//    - If in_den==0: go to DONE with out_dz=1 and out_quotient='1, skipping the datapath.
//  - LOAD (1 cycle): dp_load=1, dp_mode=0. Next state ITER with iter=0, phase=0, lat=0.
//  - ITER: dp_mode=1, dp_stage=phase, dp_rem=(iter==ITERS-1).
//    - lat increments every cycle; at lat==MUL_LAT-1, lat wraps to 0 and phase toggles.
//    - When phase wraps 1->0, iter increments.
//    - After the last cycle of iter==ITERS-1, phase 1, go to CAPTURE.
//    - ITER lasts exactly 2*ITERS*MUL_LAT cycles.
//  - CAPTURE (1 cycle): dp_mode=0; register dp_quotient into out_quotient, out_dz=0.
//    Next state DONE.
//  - DONE: out_valid=1; out_quotient/out_dz held stable until out_valid&out_ready.
//    On that handshake, out_valid drops next cycle.
//  - Back-to-back: in DONE, in_ready=out_ready (combinational).
//    - If both handshakes fire in the same cycle, latch new operands and go to LOAD (or to
//      DONE again if den==0).
//    - Otherwise, after the out handshake go to IDLE.
//  - Latency: accept at edge k -> out_valid high in the cycle after edge k+2+2*ITERS*MUL_LAT.
//    Defaults: out_valid seen after edge k+10. Zero-divisor: out_valid after edge k.
//  - flush=1: next state IDLE from any state; out_valid/dp_* deasserted next cycle.
//    flush has priority over all handshakes.
//  - dp_num/dp_den change only on an accepted input; they stay constant during LOAD..DONE.
//  - in_ready is 0 in LOAD, ITER and CAPTURE.
//    in_valid during those states is ignored (no overwrite).
// TESTING
//  - Reset: hold reset=0 three cycles -> in_ready=1, out_valid=0, busy=0, dp_*=0.
//  - Single divide, defaults: num=0x20000000, den=0x30000000 accepted at edge k.
//    Required: dp_load=1 in the cycle after edge k.
//    Required: dp_stage sequence 0,1 x4; dp_rem=1 in the last 2 ITER cycles.
//    Required: out_valid after edge k+10; out_quotient equals dp_quotient sampled in CAPTURE.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_quotient stable,
//    in_ready=0. Then out_ready=1 with in_valid=1 -> next divide enters LOAD the next cycle.
//  - Zero divisor: den=0 -> out_valid after the accept edge, out_dz=1, out_quotient=all ones;
//    dp_load never asserted.
//  - Flush in ITER at iter=2: next cycle state IDLE, busy=0, dp_mode=0, no out_valid.
//    A following divide completes normally.
//  - Params ITERS=2, MUL_LAT=3 -> ITER lasts 12 cycles, dp_stage held 3 cycles per phase,
//    out_valid after edge k+14.

Source files
------------

// File: rtl/goldschmidt_seq.sv
// Control sequencer for the Goldschmidt mantissa divider: holds one operand pair,
// steps the datapath through LOAD / ITER / CAPTURE, and presents the quotient.
module goldschmidt_seq #(
    parameter int WIDTH   = 30,
    parameter int ITERS   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    input  logic             flush,
    output logic [WIDTH-1:0] dp_num,
    output logic [WIDTH-1:0] dp_den,
    output logic             dp_load,
    output logic             dp_mode,
    output logic             dp_stage,
    output logic             dp_rem,
    input  logic [WIDTH-1:0] dp_quotient,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic             out_dz,
    output logic             busy
);

    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, CAPTURE, DONE} state_t;

    state_t        state;
    logic [IW-1:0] iter;
    logic          phase;
    logic [LW-1:0] lat;

    logic accept;
    logic last_lat;
    logic last_iter;

    assign accept    = in_valid & in_ready;
    assign last_lat  = (lat == LW'(MUL_LAT - 1));
    assign last_iter = (iter == IW'(ITERS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            iter         <= '0;
            phase        <= 1'b0;
            lat          <= '0;
            dp_num       <= '0;
            dp_den       <= '0;
            out_quotient <= '0;
            out_dz       <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            // Accepts only happen in IDLE or in DONE alongside the output handshake.
            if (accept) begin
                dp_num <= in_num;
                dp_den <= in_den;
                if (in_den == '0) begin
                    state        <= DONE;
                    out_dz       <= 1'b1;
                    out_quotient <= '1;
                end else begin
                    state <= LOAD;
                end
            end
            case (state)
                LOAD: begin
                    state <= ITER;
                    iter  <= '0;
                    phase <= 1'b0;
                    lat   <= '0;
                end
                ITER: begin
                    if (last_lat) begin
                        lat   <= '0;
                        phase <= ~phase;
                        if (phase) begin
                            if (last_iter) state <= CAPTURE;
                            else           iter  <= iter + 1'b1;
                        end
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                CAPTURE: begin
                    out_quotient <= dp_quotient;
                    out_dz       <= 1'b0;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready && !in_valid) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    // Control outputs decode directly from the registered state and counters.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        dp_load   = (state == LOAD);
        dp_mode   = (state == ITER);
        dp_stage  = (state == ITER) && phase;
        dp_rem    = (state == ITER) && last_iter;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Bench for goldschmidt_seq: schedule-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_goldschmidt_seq;

    localparam int W  = 30;
    localparam int IT = 4;
    localparam int ML = 1;
    localparam int L  = 2 * IT * ML;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_num = '0;
    logic [W-1:0] in_den = '0;
    logic         flush = 1'b0;
    logic [W-1:0] dp_quotient = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, dp_load, dp_mode, dp_stage, dp_rem, out_valid, out_dz, busy;
    logic [W-1:0] dp_num, dp_den, out_quotient;

    logic         in2_valid = 1'b0;
    logic [W-1:0] in2_num = '0;
    logic [W-1:0] in2_den = '0;
    logic         flush2 = 1'b0;
    logic         out2_ready = 1'b1;
    logic         in2_ready, d2_load, d2_mode, d2_stage, d2_rem, d2_ov, d2_dz, d2_busy;
    logic [W-1:0] d2_num, d2_den, d2_q;

    goldschmidt_seq #(.WIDTH(W), .ITERS(IT), .MUL_LAT(ML)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_den(in_den), .flush(flush),
        .dp_num(dp_num), .dp_den(dp_den), .dp_load(dp_load), .dp_mode(dp_mode),
        .dp_stage(dp_stage), .dp_rem(dp_rem), .dp_quotient(dp_quotient),
        .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
        .out_dz(out_dz), .busy(busy)
    );

    goldschmidt_seq #(.WIDTH(W), .ITERS(2), .MUL_LAT(3)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in2_valid), .in_ready(in2_ready),
        .in_num(in2_num), .in_den(in2_den), .flush(flush2),
        .dp_num(d2_num), .dp_den(d2_den), .dp_load(d2_load), .dp_mode(d2_mode),
        .dp_stage(d2_stage), .dp_rem(d2_rem), .dp_quotient(dp_quotient),
        .out_valid(d2_ov), .out_ready(out2_ready), .out_quotient(d2_q),
        .out_dz(d2_dz), .busy(d2_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k        = 0;
    int lat;
    logic [W-1:0] q0;

    // Reference model: a divide in flight is described by cycles since its accept edge.
    bit           m_active = 1'b0;
    bit           m_done   = 1'b0;
    bit           m_dz     = 1'b0;
    int           m_n      = 0;
    logic [W-1:0] m_num = '0;
    logic [W-1:0] m_den = '0;
    logic [W-1:0] m_q   = '0;

    logic stg1 [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    logic rem1 [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic stg2 [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    function void check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function void checkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function void checki(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function void model_accept();
        m_num = in_num;
        m_den = in_den;
        if (in_den == '0) begin
            m_done = 1'b1;
            m_dz   = 1'b1;
            m_q    = '1;
        end else begin
            m_active = 1'b1;
            m_n      = 1;
        end
    endfunction

    function void model_update();
        if (!reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_num    = '0;
            m_den    = '0;
        end else if (flush) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (m_active) begin
            if (m_n == L + 2) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_dz     = 1'b0;
                m_q      = dp_quotient;
            end else begin
                m_n++;
            end
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 1'b0;
                if (in_valid) model_accept();
            end
        end else if (in_valid) begin
            model_accept();
        end
    endfunction

    function void model_compare();
        bit e_mode;
        int j;
        e_mode = m_active && (m_n >= 2) && (m_n <= L + 1);
        j      = m_n - 2;
        check1("dp_load", dp_load, m_active && (m_n == 1));
        check1("dp_mode", dp_mode, e_mode);
        check1("dp_stage", dp_stage, e_mode && ((j / ML) % 2 == 1));
        check1("dp_rem", dp_rem, e_mode && (j >= L - 2 * ML));
        check1("out_valid", out_valid, m_done);
        check1("busy", busy, m_active || m_done);
        check1("in_ready", in_ready, m_done ? out_ready : !m_active);
        checkw("dp_num", dp_num, m_num);
        checkw("dp_den", dp_den, m_den);
        if (m_done) begin
            checkw("out_quotient", out_quotient, m_q);
            check1("out_dz", out_dz, m_dz);
        end
    endfunction

    task automatic nedge();
        @(negedge clk);
        model_compare();
    endtask

    task automatic pedge();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        dp_quotient = W'($urandom);
    endtask

    task automatic step();
        nedge();
        pedge();
    endtask

    task automatic wait_ov(input int bound, output int lat_o);
        lat_o = -1;
        for (int i = 0; i < bound; i++) begin
            nedge();
            if (out_valid) begin
                lat_o = cyc - k;
                break;
            end
            pedge();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) step();
        nedge();
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_dp_load", dp_load, 1'b0);
        checkw("rst_dp_num", dp_num, '0);
        pedge();
        reset = 1'b1;
        step();

        // Single divide with backpressure on the result.
        in_num = 30'h20000000; in_den = 30'h30000000; in_valid = 1'b1; out_ready = 1'b0;
        nedge();
        check1("idle_in_ready", in_ready, 1'b1);
        pedge();
        k = cyc; in_valid = 1'b0;
        nedge();
        check1("load_after_accept", dp_load, 1'b1);
        pedge();
        for (int i = 0; i < 8; i++) begin
            nedge();
            check1("iter_stage", dp_stage, stg1[i]);
            check1("iter_rem", dp_rem, rem1[i]);
            pedge();
        end
        wait_ov(20, lat);
        checki("latency", lat, 10);
        q0 = out_quotient;
        pedge();
        repeat (5) begin
            nedge();
            checkw("bp_hold_q", out_quotient, q0);
            check1("bp_valid", out_valid, 1'b1);
            check1("bp_in_ready", in_ready, 1'b0);
            pedge();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_num = 30'h1234567; in_den = 30'h2AAAAAAA;
        nedge();
        check1("b2b_in_ready", in_ready, 1'b1);
        pedge();
        k = cyc; in_valid = 1'b0;
        nedge();
        check1("b2b_load", dp_load, 1'b1);
        pedge();
        wait_ov(20, lat);
        checki("b2b_latency", lat, 10);
        pedge();
        step();

        // Zero divisor bypasses the datapath.
        in_valid = 1'b1; in_num = W'($urandom); in_den = '0; out_ready = 1'b0;
        nedge();
        pedge();
        k = cyc; in_valid = 1'b0;
        nedge();
        check1("dz_valid", out_valid, 1'b1);
        check1("dz_flag", out_dz, 1'b1);
        checkw("dz_quotient", out_quotient, 30'h3FFFFFFF);
        check1("dz_no_load", dp_load, 1'b0);
        pedge();
        out_ready = 1'b1;
        step();
        step();

        // Flush during the third iteration, then a normal divide.
        in_valid = 1'b1; in_num = 30'h0F0F0F0F; in_den = 30'h15555555;
        nedge();
        pedge();
        k = cyc; in_valid = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        nedge();
        check1("flush_pre_mode", dp_mode, 1'b1);
        pedge();
        flush = 1'b0;
        nedge();
        check1("flush_busy", busy, 1'b0);
        check1("flush_mode", dp_mode, 1'b0);
        check1("flush_ov", out_valid, 1'b0);
        pedge();
        repeat (12) step();
        in_valid = 1'b1; in_num = 30'h3000000; in_den = 30'h2000001;
        nedge();
        pedge();
        k = cyc; in_valid = 1'b0;
        wait_ov(20, lat);
        checki("post_flush_latency", lat, 10);
        pedge();
        step();

        // Randomized traffic.
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_num    = W'($urandom);
            in_den    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (L + 5) step();

        // Alternate parameters: ITERS=2, MUL_LAT=3.
        in2_valid = 1'b1; in2_num = 30'h10000000; in2_den = 30'h28000000;
        nedge();
        pedge();
        k = cyc; in2_valid = 1'b0;
        nedge();
        check1("p2_load", d2_load, 1'b1);
        pedge();
        for (int i = 0; i < 12; i++) begin
            nedge();
            check1("p2_mode", d2_mode, 1'b1);
            check1("p2_stage", d2_stage, stg2[i]);
            pedge();
        end
        nedge();
        check1("p2_mode_end", d2_mode, 1'b0);
        check1("p2_ov_early", d2_ov, 1'b0);
        pedge();
        nedge();
        check1("p2_ov", d2_ov, 1'b1);
        checki("p2_latency", cyc - k, 14);
        pedge();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
